// File: rtl/right_shift_seq_32bit.sv
// Iterative right shifter: moves one bit position per clock, logical or arithmetic fill.
// Valid/ready on both sides. Only one operation is in flight at a time.

module rsh_lane (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic shift,
   input  logic ld_bit,
   input  logic sh_bit,
   output logic q
);
   always_ff @(posedge clk) begin
      if (rst)        q <= 1'b0;
      else if (load)  q <= ld_bit;
      else if (shift) q <= sh_bit;
   end
endmodule

module right_shift_seq_32bit #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [SHAMT_W-1:0] b,
   input  logic               arith,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out
);
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

   state_t             state, state_nx;
   logic [WIDTH-1:0]   data;
   logic [SHAMT_W-1:0] count;
   logic               fill;
   logic               load, shift;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         fill  <= 1'b0;
      end else if (load) begin
         count <= b;
         fill  <= arith & a[WIDTH-1];
      end else if (shift) begin
         count <= count - SHAMT_W'(1);
      end
   end

   // Handshake outputs come from state alone so no input-to-output comb path exists.
   always_comb begin
      state_nx  = state;
      load      = 1'b0;
      shift     = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load     = 1'b1;
               state_nx = (b == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            shift = 1'b1;
            if (count == SHAMT_W'(1)) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Bit-slice lanes; the top lane takes the fill bit, others take their upper neighbour.
   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      logic sh_in;
      if (i == WIDTH-1) begin : g_top
         assign sh_in = fill;
      end else begin : g_mid
         assign sh_in = data[i+1];
      end
      rsh_lane u_lane (
         .clk    (clk),
         .rst    (rst),
         .load   (load),
         .shift  (shift),
         .ld_bit (a[i]),
         .sh_bit (sh_in),
         .q      (data[i])
      );
   end

   assign out = data;

endmodule

// File: tb/tb_right_shift_seq_32bit.sv
// Scoreboard bench for right_shift_seq_32bit: directed cases plus randomized traffic.

module tb_right_shift_seq_32bit;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] a;
   logic [4:0]  b;
   logic        arith;
   logic        out_valid, out_ready;
   logic [31:0] out;

   right_shift_seq_32bit dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .arith(arith), .out_valid(out_valid),
      .out_ready(out_ready), .out(out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] exp;
      int          sh;
      int          e0;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   ntests = 0;
   int   nfail = 0;
   logic hold = 1'b1;
   logic hold_val = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ref_shift(input logic [31:0] v, input int n, input logic ar);
      logic signed [31:0] s;
      s = v;
      return ar ? 32'(s >>> n) : (v >> n);
   endfunction

   // Consumer: random backpressure unless the main sequence takes control.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #2;
         out_ready = hold ? hold_val : ($urandom_range(0, 9) < 7);
      end
   end

   // Monitor: compares whatever the DUT presents against the head of the scoreboard.
   initial begin
      bit seen = 0;
      forever begin
         @(negedge clk);
         if (rst) seen = 0;
         else if (out_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_result", out, 32'hx);
            end else begin
               chk("result", out, sb[0].exp);
               chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
               if (!seen) chk("latency", 32'(cyc - sb[0].e0), 32'(sb[0].sh));
               seen = 1;
               if (out_ready) begin
                  void'(sb.pop_front());
                  seen = 0;
               end
            end
         end
      end
   end

   // Issue one operation; while the DUT is busy, wiggle in_valid/operands with junk.
   task automatic do_op(input logic [31:0] va, input logic [4:0] vb, input logic var_);
      int n = 0;
      forever begin
         if (in_ready) begin
            in_valid = 1'b1; a = va; b = vb; arith = var_;
            @(posedge clk); #1;
            sb.push_back('{exp: ref_shift(va, int'(vb), var_), sh: int'(vb), e0: cyc});
            in_valid = $urandom_range(0, 1); a = $urandom; b = 5'($urandom); arith = $urandom_range(0, 1);
            if (in_ready) in_valid = 1'b0;
            return;
         end
         in_valid = $urandom_range(0, 1); a = $urandom; b = 5'($urandom); arith = $urandom_range(0, 1);
         @(posedge clk); #1;
         n++;
         if (n > 200) begin
            chk("accept_timeout", 32'(n), 32'd0);
            return;
         end
      end
   endtask

   task automatic drain();
      int n = 0;
      in_valid = 1'b0;
      while (sb.size() != 0 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; arith = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_out", out, 32'd0);
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

      hold = 1'b0;
      do_op(32'h8000_0000, 5'd4, 1'b0);
      do_op(32'h8000_0000, 5'd4, 1'b1);
      do_op(32'h1234_5678, 5'd0, 1'b0);
      do_op(32'h8000_0000, 5'd31, 1'b1);
      do_op(32'h8000_0000, 5'd31, 1'b0);
      drain();
      // Pin the spec's literal results independently of the reference function.
      chk("ref_sra4", ref_shift(32'h8000_0000, 4, 1'b1), 32'hF800_0000);
      chk("ref_sra31", ref_shift(32'h8000_0000, 31, 1'b1), 32'hFFFF_FFFF);

      // Hold the result in DONE with a competing operand on the input.
      hold = 1'b1; hold_val = 1'b0;
      repeat (2) @(posedge clk); #1;
      do_op(32'hC0DE_0001, 5'd3, 1'b1);
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; a = $urandom; b = 5'($urandom); arith = 1'b1;
         @(posedge clk); #1;
         if (i >= 3) begin
            chk("hold_out", out, ref_shift(32'hC0DE_0001, 3, 1'b1));
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
         end
      end
      in_valid = 1'b0;
      hold_val = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("release_in_ready", {31'd0, in_ready}, 32'd1);
      chk("release_out_valid", {31'd0, out_valid}, 32'd0);
      chk("release_sb_empty", 32'(sb.size()), 32'd0);

      // Reset in the middle of a shift abandons the operation.
      hold_val = 1'b1;
      do_op(32'hDEAD_BEEF, 5'd20, 1'b1);
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      void'(sb.pop_back());
      chk("midrst_out", out, 32'd0);
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      hold = 1'b0;
      do_op(32'hFFFF_0000, 5'd16, 1'b0);
      drain();

      for (int i = 0; i < 60; i++) begin
         logic [31:0] ra;
         ra = $urandom;
         if (i % 4 == 0) ra[31] = 1'b1;
         do_op(ra, 5'($urandom), $urandom_range(0, 1));
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d failures so far", nfail);
      $fatal(1, "watchdog");
   end
endmodule
